// File: rtl/mem_pkg.sv
// Shared types and widths for the data-memory responder.
package mem_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned BE_W = 4;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StWait   = 2'd1,
        StAccess = 2'd2,
        StResp   = 2'd3
    } state_e;

endpackage

// File: rtl/ram_be_sp.sv
// Single-port word RAM: per-byte write enable on the rising edge, combinational read.
module ram_be_sp
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [BE_W-1:0]   i_be,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [XLEN-1:0]   i_wdata,
    output logic [XLEN-1:0]   o_rdata
);

    localparam int unsigned Depth = 1 << ADDR_W;

    logic [XLEN-1:0] r_mem [Depth];

    // Contents are intentionally never reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(BE_W); i++) begin
            if (i_we && i_be[i]) begin
                r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/d_mem_responder.sv
// Memory-side responder for the core's data port: one request at a time,
// WAIT_CYCLES wait states, then a held response until the initiator accepts it.
module d_mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_req_valid,
    output logic            o_req_ready,
    input  logic            i_req_we,
    input  logic [XLEN-1:0] i_req_addr,
    input  logic [XLEN-1:0] i_req_wdata,
    input  logic [BE_W-1:0] i_req_be,
    output logic            o_rsp_valid,
    input  logic            i_rsp_ready,
    output logic [XLEN-1:0] o_rsp_rdata,
    output logic            o_rsp_err
);

    localparam logic [3:0] LastWait = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_e          r_state;
    logic [3:0]      r_wait_cnt;
    logic            r_we;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [BE_W-1:0] r_be;
    logic            r_rsp_valid;
    logic [XLEN-1:0] r_rsp_rdata;
    logic            r_rsp_err;

    logic            w_misaligned;
    logic            w_out_of_range;
    logic            w_err;
    logic            w_mem_we;
    logic [XLEN-1:0] w_rdata;

    assign w_misaligned   = |r_addr[1:0];
    assign w_out_of_range = |(r_addr >> (ADDR_W + 2));
    assign w_err          = w_misaligned | w_out_of_range;

    // Gated by rst_n so a reset landing on the ACCESS edge leaves memory untouched.
    assign w_mem_we = (r_state == StAccess) && rst_n && r_we && !w_err;

    assign o_req_ready = rst_n && (r_state == StIdle);
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_err   = r_rsp_err;

    ram_be_sp #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_be    (r_be),
        .i_addr  (r_addr[ADDR_W+1:2]),
        .i_wdata (r_wdata),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_wait_cnt  <= 4'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_req_valid) begin
                        r_we       <= i_req_we;
                        r_addr     <= i_req_addr;
                        r_wdata    <= i_req_wdata;
                        r_be       <= i_req_be;
                        r_wait_cnt <= 4'd0;
                        r_state    <= (WAIT_CYCLES > 0) ? StWait : StAccess;
                    end
                end
                StWait: begin
                    if (r_wait_cnt == LastWait) begin
                        r_wait_cnt <= 4'd0;
                        r_state    <= StAccess;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 4'd1;
                    end
                end
                StAccess: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= w_err;
                    r_rsp_rdata <= (w_err || r_we) ? '0 : w_rdata;
                    r_state     <= StResp;
                end
                StResp: begin
                    if (i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_d_mem_responder.sv
// Bench for d_mem_responder: directed scenarios plus random traffic against a
// transaction-level model that predicts handshakes, latency and memory contents.
module tb_d_mem_responder;

    localparam int unsigned AW = 10;
    localparam int unsigned W  = 2;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;

    d_mem_responder #(
        .ADDR_W      (AW),
        .WAIT_CYCLES (W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_we    (req_we),
        .i_req_addr  (req_addr),
        .i_req_wdata (req_wdata),
        .i_req_be    (req_be),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_rdata (rsp_rdata),
        .o_rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: memory image plus the outstanding request and its timing.
    logic [31:0] m_mem   [1 << AW];
    bit          m_known [1 << AW];
    bit          m_started = 0;
    bit          m_busy    = 0;
    bit          m_valid   = 0;
    bit          m_post_rst = 0;
    bit          m_rd_known = 1;
    int          m_edges_left;
    logic        m_we;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_be;
    logic        m_err;

    task automatic model_access();
        int idx;
        idx   = int'(m_addr[AW+1:2]);
        m_err = (m_addr[1:0] != 2'b00) || ((m_addr >> (AW + 2)) != 0);
        m_rdata    = 32'h0;
        m_rd_known = 1;
        if (!m_err && m_we) begin
            for (int b = 0; b < 4; b++)
                if (m_be[b]) m_mem[idx][8*b +: 8] = m_wdata[8*b +: 8];
            if (m_be == 4'hF) m_known[idx] = 1;
        end else if (!m_err) begin
            m_rdata    = m_mem[idx];
            m_rd_known = m_known[idx];
        end
    endtask

    // Compare what the last edge produced, then predict the coming edge from current inputs.
    always @(negedge clk) begin
        if (m_started) begin
            chk("req_ready", 32'(req_ready), 32'(rst_n && !m_busy));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
            if (m_valid || m_post_rst) begin
                if (m_rd_known) chk("rsp_rdata", rsp_rdata, m_rdata);
                chk("rsp_err", 32'(rsp_err), 32'(m_err));
            end
        end
        if (!rst_n) begin
            m_started  = 1;
            m_busy     = 0;
            m_valid    = 0;
            m_post_rst = 1;
            m_rdata    = 32'h0;
            m_err      = 1'b0;
            m_rd_known = 1;
        end else if (m_started) begin
            if (!m_busy) begin
                if (req_valid) begin
                    m_busy       = 1;
                    m_we         = req_we;
                    m_addr       = req_addr;
                    m_wdata      = req_wdata;
                    m_be         = req_be;
                    m_edges_left = W + 1;
                end
            end else if (!m_valid) begin
                m_edges_left--;
                if (m_edges_left == 0) begin
                    model_access();
                    m_valid    = 1;
                    m_post_rst = 0;
                end
            end else if (rsp_ready) begin
                m_valid = 0;
                m_busy  = 0;
            end
        end
    end

    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input int hold,
                       output logic [31:0] rd, output logic er, output int lat);
        int n;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        rsp_ready = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 50);
        chk("accept", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        // Scramble request fields after acceptance; they must not matter.
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_be    = 4'($urandom);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!rsp_valid && lat < 40);
        chk("rsp_seen", 32'(rsp_valid), 32'd1);
        rd = rsp_rdata;
        er = rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rdata", rsp_rdata, rd);
            chk("hold_err", 32'(rsp_err), 32'(er));
            chk("hold_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("idle_after_rsp", 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          r;

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; req_be = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);

        txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, lat);
        chk("store_lat", 32'(lat), 32'd3);
        chk("store_err", 32'(er), 32'd0);
        chk("store_rdata", rd, 32'h0);
        txn(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
        chk("load_10", rd, 32'hDEADBEEF);

        txn(1'b1, 32'h20, 32'h0, 4'hF, 0, rd, er, lat);
        txn(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, rd, er, lat);
        txn(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat);
        chk("partial_load", rd, 32'h00BB00DD);
        txn(1'b1, 32'h20, 32'h11223344, 4'h0, 0, rd, er, lat);
        txn(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat);
        chk("be0_nochange", rd, 32'h00BB00DD);

        txn(1'b1, 32'h0, 32'h12345678, 4'hF, 0, rd, er, lat);
        txn(1'b0, 32'h13, 32'h0, 4'h0, 0, rd, er, lat);
        chk("misalign_err", 32'(er), 32'd1);
        chk("misalign_rdata", rd, 32'h0);
        txn(1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 0, rd, er, lat);
        chk("oor_err", 32'(er), 32'd1);
        txn(1'b0, 32'h0, 32'h0, 4'h0, 0, rd, er, lat);
        chk("word0_unchanged", rd, 32'h12345678);

        txn(1'b0, 32'h10, 32'h0, 4'h0, 5, rd, er, lat);
        chk("bp_rdata", rd, 32'hDEADBEEF);

        // Reset during WAIT of a store must abort it without touching memory.
        txn(1'b1, 32'h30, 32'hCAFEF00D, 4'hF, 0, rd, er, lat);
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30;
        req_wdata = 32'h11111111; req_be = 4'hF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("no_rsp_after_rst", 32'(rsp_valid), 32'd0);
        end
        txn(1'b0, 32'h30, 32'h0, 4'h0, 0, rd, er, lat);
        chk("abort_kept_value", rd, 32'hCAFEF00D);

        for (int w = 0; w < 16; w++)
            txn(1'b1, 32'(w * 4), $urandom, 4'hF, 0, rd, er, lat);

        // Random traffic; the model checks every cycle.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            rst_n     = ($urandom_range(0, 99) != 0);
            req_valid = 1'($urandom);
            req_we    = 1'($urandom);
            req_wdata = $urandom;
            req_be    = 4'($urandom);
            rsp_ready = ($urandom_range(0, 2) != 0);
            r = int'($urandom_range(0, 15));
            if (r < 12)      req_addr = 32'($urandom_range(0, 15) * 4);
            else if (r < 14) req_addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
            else             req_addr = 32'h1000 + 32'($urandom_range(0, 15) * 4);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("drained", 32'(req_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
